sobel_window_ctrl: RTL and testbench

Sequencer for the Sobel edge-detection datapath. It walks every 3x3 window of a raster-stored image in a pixel RAM, issues the nine tap reads per window, and starts the Sobel core. It writes each core result to the output RAM at the window index, then flags completion on `done`. It sits between the pixel/result memories and the Sobel core inside the Sobel top level.

---
 rtl/sobel_window_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_ctrl.sv
// Window sequencer for the Sobel datapath: walks every 3x3 window of a raster image,
// fetches its nine taps, runs the core and stores each result at the window index.
module sobel_window_ctrl #(
   parameter int unsigned img_width  = 225,
   parameter int unsigned img_height = 225,
   parameter int unsigned addr_width = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   output logic                  rd_en_o,
   output logic [addr_width-1:0] rd_addr_o,
   output logic                  tap_we_o,
   output logic [3:0]            tap_sel_o,
   output logic                  core_start_o,
   input  logic                  core_done_i,
   output logic                  wr_en_o,
   output logic [addr_width-1:0] wr_addr_o,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef logic [addr_width-1:0] addr_t;

   localparam addr_t W     = addr_t'(img_width);
   localparam addr_t W1    = addr_t'(img_width + 1);
   localparam addr_t W2    = addr_t'(img_width + 2);
   localparam addr_t W20   = addr_t'(2 * img_width);
   localparam addr_t W21   = addr_t'(2 * img_width + 1);
   localparam addr_t W22   = addr_t'(2 * img_width + 2);
   localparam addr_t CLast = addr_t'(img_width - 3);
   localparam addr_t RLast = addr_t'(img_height - 3);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLoad,
      StStart,
      StWait,
      StWrite,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] k_q, k_d;
   addr_t      r_q, r_d;
   addr_t      c_q, c_d;
   addr_t      base_q, base_d;
   addr_t      widx_q, widx_d;
   addr_t      tap_off;

   logic       rd_en_q, rd_en_d;
   addr_t      rd_addr_q, rd_addr_d;
   logic       tap_we_q, tap_we_d;
   logic [3:0] tap_sel_q, tap_sel_d;
   logic       core_start_q, core_start_d;
   logic       wr_en_q, wr_en_d;
   addr_t      wr_addr_q, wr_addr_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      r_d     = r_q;
      c_d     = c_q;
      base_d  = base_q;
      widx_d  = widx_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d = StFetch;
               k_d     = 4'd0;
               r_d     = '0;
               c_d     = '0;
               base_d  = '0;
               widx_d  = '0;
            end
         end
         StFetch: begin
            if (k_q == 4'd8) begin
               state_d = StLoad;
               k_d     = 4'd0;
            end else begin
               k_d = k_q + 4'd1;
            end
         end
         StLoad:  state_d = StStart;
         StStart: state_d = StWait;
         StWait: begin
            if (core_done_i) state_d = StWrite;
         end
         StWrite: begin
            if (r_q == RLast && c_q == CLast) begin
               state_d = StDone;
            end else begin
               state_d = StFetch;
               widx_d  = widx_q + addr_t'(1);
               if (c_q < CLast) begin
                  c_d    = c_q + addr_t'(1);
                  base_d = base_q + addr_t'(1);
               end else begin
                  // Row wrap skips the two columns that cannot host a window.
                  c_d    = '0;
                  r_d    = r_q + addr_t'(1);
                  base_d = base_q + addr_t'(3);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      case (k_d)
         4'd0:    tap_off = '0;
         4'd1:    tap_off = addr_t'(1);
         4'd2:    tap_off = addr_t'(2);
         4'd3:    tap_off = W;
         4'd4:    tap_off = W1;
         4'd5:    tap_off = W2;
         4'd6:    tap_off = W20;
         4'd7:    tap_off = W21;
         4'd8:    tap_off = W22;
         default: tap_off = '0;
      endcase
   end

   // Outputs are decoded from the next state so every port comes straight from a flop.
   always_comb begin
      rd_en_d      = (state_d == StFetch);
      rd_addr_d    = rd_en_d ? base_d + tap_off : '0;
      tap_we_d     = rd_en_q;
      tap_sel_d    = rd_en_q ? k_q : 4'd0;
      core_start_d = (state_d == StStart);
      wr_en_d      = (state_d == StWrite);
      wr_addr_d    = wr_en_d ? widx_d : '0;
      busy_d       = (state_d != StIdle) && (state_d != StDone);
      done_d       = (state_d == StDone);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= StIdle;
         k_q          <= 4'd0;
         r_q          <= '0;
         c_q          <= '0;
         base_q       <= '0;
         widx_q       <= '0;
         rd_en_q      <= 1'b0;
         rd_addr_q    <= '0;
         tap_we_q     <= 1'b0;
         tap_sel_q    <= 4'd0;
         core_start_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         r_q          <= r_d;
         c_q          <= c_d;
         base_q       <= base_d;
         widx_q       <= widx_d;
         rd_en_q      <= rd_en_d;
         rd_addr_q    <= rd_addr_d;
         tap_we_q     <= tap_we_d;
         tap_sel_q    <= tap_sel_d;
         core_start_q <= core_start_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign rd_en_o      = rd_en_q;
   assign rd_addr_o    = rd_addr_q;
   assign tap_we_o     = tap_we_q;
   assign tap_sel_o    = tap_sel_q;
   assign core_start_o = core_start_q;
   assign wr_en_o      = wr_en_q;
   assign wr_addr_o    = wr_addr_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl on a non-square 6x5 image with a randomized
// core latency, stray core_done/start pulses and a mid-pass reset.
module tb_sobel_window_ctrl;

   localparam int unsigned W    = 6;
   localparam int unsigned H    = 5;
   localparam int unsigned AW   = 16;
   localparam int          NWIN = (W - 2) * (H - 2);

   logic          clk = 1'b0;
   logic          reset, start, core_done;
   logic          rd_en, tap_we, core_start, wr_en, busy, done;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [3:0]    tap_sel;
   logic [41:0]   outs;

   int n_vec = 0, n_err = 0;
   int cyc = 0, cs_count = 0, cd_cnt = 0;
   bit noise_on = 1'b0, prev_rd = 1'b0;
   int rd_exp[$], tap_exp[$], wr_exp[$], lat_q[$], win_len[$];

   sobel_window_ctrl #(
      .img_width (W),
      .img_height(H),
      .addr_width(AW)
   ) u_dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .start_i     (start),
      .rd_en_o     (rd_en),
      .rd_addr_o   (rd_addr),
      .tap_we_o    (tap_we),
      .tap_sel_o   (tap_sel),
      .core_start_o(core_start),
      .core_done_i (core_done),
      .wr_en_o     (wr_en),
      .wr_addr_o   (wr_addr),
      .busy_o      (busy),
      .done_o      (done)
   );

   assign outs = {rd_en, rd_addr, tap_we, tap_sel, core_start, wr_en, wr_addr, busy, done};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic void unexpected(input string name, input logic [63:0] act);
      n_vec++;
      n_err++;
      $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
   endfunction

   // Reference: every window in raster order, taps row-major inside the window.
   task automatic build_pass(input bit rand_lat, output int total);
      total = 1;
      win_len.delete();
      for (int r = 0; r <= int'(H) - 3; r++) begin
         for (int c = 0; c <= int'(W) - 3; c++) begin
            int base = r * int'(W) + c;
            int lat  = rand_lat ? int'($urandom_range(1, 4)) : 1;
            for (int k = 0; k < 9; k++) begin
               rd_exp.push_back(base + (k / 3) * int'(W) + (k % 3));
               tap_exp.push_back(k);
            end
            wr_exp.push_back(r * (int'(W) - 2) + c);
            lat_q.push_back(lat);
            win_len.push_back(12 + lat);
            total += 12 + lat;
         end
      end
   endtask

   // Core model: answers each core_start after its chosen latency; may inject stray pulses.
   initial begin : responder
      core_done = 1'b0;
      forever begin
         @(negedge clk);
         core_done = 1'b0;
         if (reset) begin
            cd_cnt = 0;
         end else begin
            if (cd_cnt > 0) begin
               cd_cnt--;
               if (cd_cnt == 0) core_done = 1'b1;
            end else if (noise_on && (rd_en || wr_en) && $urandom_range(0, 2) == 0) begin
               core_done = 1'b1;
            end
            if (core_start) cd_cnt = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (reset) begin
            chk("reset_outputs", 64'(outs), 64'd0);
            prev_rd = 1'b0;
         end else begin
            chk("tap_we_lag", 64'(tap_we), 64'(prev_rd));
            if (rd_en) begin
               if (rd_exp.size() == 0) unexpected("rd_addr", 64'(rd_addr));
               else chk("rd_addr", 64'(rd_addr), 64'(rd_exp.pop_front()));
            end
            if (tap_we) begin
               if (tap_exp.size() == 0) unexpected("tap_sel", 64'(tap_sel));
               else chk("tap_sel", 64'(tap_sel), 64'(tap_exp.pop_front()));
            end
            if (wr_en) begin
               if (wr_exp.size() == 0) unexpected("wr_addr", 64'(wr_addr));
               else chk("wr_addr", 64'(wr_addr), 64'(wr_exp.pop_front()));
            end
            if (core_start) cs_count++;
            chk("busy_done_excl", 64'(busy & done), 64'd0);
            prev_rd = rd_en;
         end
      end
   end

   task automatic run_pass(input bit rand_lat, input bit noise, input bit abort);
      int  total, t0, cs0, target;
      bit  got, last_busy, prev_cs;
      build_pass(rand_lat, total);
      cs0 = cs_count;
      @(negedge clk);
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      chk("first_cycle_done", 64'(done), 64'd0);
      chk("first_cycle_busy", 64'(busy), 64'd1);
      chk("first_cycle_rd_en", 64'(rd_en), 64'd1);
      if (abort) begin
         // Window 4, tap 5.
         target = 1 + 5;
         for (int i = 0; i < 4; i++) target += win_len[i];
         while (cyc < t0 + target) @(negedge clk);
         #2 reset = 1'b1;
         #1 chk("reset_async", 64'(outs), 64'd0);
         rd_exp.delete();
         tap_exp.delete();
         wr_exp.delete();
         lat_q.delete();
         repeat (3) @(negedge clk);
         #2 reset = 1'b0;
         repeat (2) @(negedge clk);
         chk("idle_after_reset", 64'({busy, done, rd_en}), 64'd0);
         return;
      end
      noise_on  = noise;
      got       = 1'b0;
      last_busy = busy;
      prev_cs   = 1'b0;
      for (int n = 0; n < total + 40; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            got = 1'b1;
            break;
         end
         // prev_cs marks the first WAIT cycle; start there must be ignored.
         if (noise && busy && (prev_cs || $urandom_range(0, 24) == 0)) start = 1'b1;
         prev_cs   = core_start;
         last_busy = busy;
      end
      start    = 1'b0;
      noise_on = 1'b0;
      if (!got) begin
         unexpected("done_timeout", 64'(cyc - t0));
      end else begin
         chk("done_cycle", 64'(cyc - t0), 64'(total));
         chk("busy_before_done", 64'(last_busy), 64'd1);
         chk("busy_at_done", 64'(busy), 64'd0);
      end
      chk("core_start_count", 64'(cs_count - cs0), 64'(NWIN));
      chk("reads_left", 64'(rd_exp.size()), 64'd0);
      chk("taps_left", 64'(tap_exp.size()), 64'd0);
      chk("writes_left", 64'(wr_exp.size()), 64'd0);
      repeat (4) @(negedge clk);
      chk("done_held", 64'({busy, done}), 64'd1);
   endtask

   initial begin : stimulus
      reset = 1'b0;
      start = 1'b0;
      #3 reset = 1'b1;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_after_por", 64'(outs), 64'd0);
      run_pass(1'b0, 1'b0, 1'b0);
      run_pass(1'b1, 1'b1, 1'b0);
      run_pass(1'b1, 1'b0, 1'b1);
      run_pass(1'b1, 1'b1, 1'b0);
      run_pass(1'b0, 1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
